mips_instr_encoder: RTL and testbench

Sequential instruction encoder and program loader for the MIPS core. It accepts one symbolic instruction per handshake (format select plus register, immediate and target fields). For each instruction it packs the 32-bit MIPS machine word, which is the exact inverse of the opcode decoding done by the control unit, and writes the word into instruction memory at consecutive word addresses. It sits between a host/boot source and the instruction-memory write port, and is used to preload programs before the core is released.

---
 rtl/mips_pkg.sv | 24 ++
 rtl/mips_instr_pack.sv | 31 +++
 rtl/mips_instr_encoder.sv | 151 +++++++++++++++
 tb/tb_mips_instr_encoder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS constants: primary opcodes (also used by the control-unit decode),
// encoder op_sel codes and the loader FSM state type.
package mips_pkg;

    localparam logic [5:0] R_TYPE = 6'h00;
    localparam logic [5:0] ADDI   = 6'h08;
    localparam logic [5:0] ORI    = 6'h0D;
    localparam logic [5:0] ANDI   = 6'h0C;
    localparam logic [5:0] J      = 6'h02;

    localparam logic [2:0] OP_RTYPE = 3'd0;
    localparam logic [2:0] OP_ADDI  = 3'd1;
    localparam logic [2:0] OP_ORI   = 3'd2;
    localparam logic [2:0] OP_ANDI  = 3'd3;
    localparam logic [2:0] OP_J     = 3'd4;

    typedef logic [1:0] encState_t;

    localparam encState_t S_IDLE   = 2'd0;
    localparam encState_t S_ACCEPT = 2'd1;
    localparam encState_t S_WRITE  = 2'd2;
    localparam encState_t S_DONE   = 2'd3;

endpackage

// File: rtl/mips_instr_pack.sv
// Combinational field packer: op_sel plus instruction fields to a 32-bit MIPS word.
// Unknown op_sel values pack to zero (NOP) and raise the illegal flag.
module mips_instr_pack
    import mips_pkg::*;
(
    input  logic [2:0]  opSel,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = 32'h0000_0000;
        illegal = 1'b0;
        case (opSel)
            OP_RTYPE: word = {R_TYPE, rs, rt, rd, shamt, funct};
            OP_ADDI:  word = {ADDI, rs, rt, imm};
            OP_ORI:   word = {ORI, rs, rt, imm};
            OP_ANDI:  word = {ANDI, rs, rt, imm};
            OP_J:     word = {J, target};
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// Program loader: encodes one handshaken instruction at a time and writes it to
// consecutive imem word addresses. ENCODER_CHECK_EN drops illegal op_sel with an err pulse.
//
// state    | meaning
// IDLE     | waiting for start, no requests taken
// ACCEPT   | req_ready while not full; captures the packed word
// WRITE    | one-cycle imem write at BASE + word_count
// DONE     | one-cycle done pulse, then IDLE
module mips_instr_encoder
    import mips_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 64,
    parameter int BASE   = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_last,
    input  logic [2:0]        op_sel,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              busy,
    output logic              done,
    output logic              err
);

    if (BASE + DEPTH > (1 << ADDR_W)) begin : gBadRange
        $error("mips_instr_encoder: BASE + DEPTH exceeds the imem address space");
    end

    localparam logic [ADDR_W:0]   depthW = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   oneW   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] baseW  = ADDR_W'(BASE);

    encState_t         state;
    logic [ADDR_W:0]   wordCount;
    logic [ADDR_W:0]   countInc;
    logic [ADDR_W-1:0] addrQ;
    logic [31:0]       wdataQ;
    logic              lastQ;
    logic [31:0]       packWord;
    logic              packIllegal;
    logic              notFull;
    logic              accept;

    mips_instr_pack uPack (
        .opSel   (op_sel),
        .rs      (rs),
        .rt      (rt),
        .rd      (rd),
        .shamt   (shamt),
        .funct   (funct),
        .imm     (imm),
        .target  (target),
        .word    (packWord),
        .illegal (packIllegal)
    );

    assign countInc = wordCount + oneW;
    assign notFull  = (wordCount < depthW);
    assign accept   = (state == S_ACCEPT) && notFull && req_valid;

`ifdef ENCODER_CHECK_EN
    logic errQ;
    logic dropReq;

    assign dropReq = packIllegal;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            errQ <= 1'b0;
        end else begin
            errQ <= accept && packIllegal;
        end
    end

    assign err = errQ;
`else
    logic unusedIllegal;
    logic dropReq;

    // Illegal codes already pack to NOP and are written like any other word.
    assign unusedIllegal = packIllegal;
    assign dropReq       = 1'b0;
    assign err           = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            wordCount <= '0;
            addrQ     <= '0;
            wdataQ    <= '0;
            lastQ     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        wordCount <= '0;
                        state     <= S_ACCEPT;
                    end
                end
                S_ACCEPT: begin
                    if (!notFull) begin
                        state <= S_DONE;
                    end else if (accept) begin
                        if (dropReq) begin
                            state <= req_last ? S_DONE : S_ACCEPT;
                        end else begin
                            wdataQ <= packWord;
                            addrQ  <= baseW + wordCount[ADDR_W-1:0];
                            lastQ  <= req_last;
                            state  <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    wordCount <= countInc;
                    state     <= (lastQ || countInc == depthW) ? S_DONE : S_ACCEPT;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state == S_ACCEPT) && notFull;
    assign imem_we    = (state == S_WRITE);
    assign imem_addr  = addrQ;
    assign imem_wdata = wdataQ;
    assign word_count = wordCount;
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench for mips_instr_encoder (DEPTH=4, BASE=0); expectations follow
// ENCODER_CHECK_EN when the bench is built with it.
module tb_mips_instr_encoder;

    localparam int ADDR_W = 8;

    logic              clk;
    logic              reset;
    logic              start;
    logic              reqValid;
    logic              reqReady;
    logic              reqLast;
    logic [2:0]        opSel;
    logic [4:0]        rs, rt, rd, shamt;
    logic [5:0]        funct;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              imemWe;
    logic [ADDR_W-1:0] imemAddr;
    logic [31:0]       imemWdata;
    logic [ADDR_W:0]   wordCount;
    logic              busy;
    logic              done;
    logic              err;

    int vectors     = 0;
    int miscompares = 0;

    mips_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(4), .BASE(0)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .req_valid  (reqValid),
        .req_ready  (reqReady),
        .req_last   (reqLast),
        .op_sel     (opSel),
        .rs         (rs),
        .rt         (rt),
        .rd         (rd),
        .shamt      (shamt),
        .funct      (funct),
        .imm        (imm),
        .target     (target),
        .imem_we    (imemWe),
        .imem_addr  (imemAddr),
        .imem_wdata (imemWdata),
        .word_count (wordCount),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for req_ready, then holds the request across one edge.
    // Returns 1 ns after the accepting edge.
    task automatic apply(input logic [2:0] op, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] c, input logic [5:0] f, input logic [15:0] i,
                         input logic [25:0] t, input logic last);
        int n = 0;
        opSel = op; rs = a; rt = b; rd = c; shamt = 5'd0; funct = f; imm = i; target = t;
        reqLast = last;
        while (!reqReady && n < 20) begin
            tick();
            n++;
        end
        chk("ready_before_req", {31'd0, reqReady}, 32'd1);
        reqValid = 1'b1;
        tick();
        reqValid = 1'b0;
        reqLast  = 1'b0;
    endtask

    task automatic startSession();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; reqValid = 1'b0; reqLast = 1'b0;
        opSel = 3'd0; rs = 5'd0; rt = 5'd0; rd = 5'd0; shamt = 5'd0;
        funct = 6'd0; imm = 16'd0; target = 26'd0;
        tick(); tick();

        chk("rst_we",     {31'd0, imemWe},          32'd0);
        chk("rst_addr",   {24'd0, imemAddr},        32'd0);
        chk("rst_wdata",  imemWdata,                32'd0);
        chk("rst_count",  {23'd0, wordCount},       32'd0);
        chk("rst_flags",  {28'd0, busy, done, err, reqReady}, 32'd0);
        reset = 1'b1;
        tick();

        // Single ADDI with last
        startSession();
        chk("t1_ready", {31'd0, reqReady}, 32'd1);
        apply(3'd1, 5'd0, 5'd8, 5'd0, 6'd0, 16'd5, 26'd0, 1'b1);
        chk("t1_we",    {31'd0, imemWe},    32'd1);
        chk("t1_addr",  {24'd0, imemAddr},  32'd0);
        chk("t1_data",  imemWdata,          32'h2008_0005);
        chk("t1_rdy_w", {31'd0, reqReady},  32'd0);
        tick();
        chk("t1_done",  {30'd0, done, imemWe}, 32'd2);
        chk("t1_count", {23'd0, wordCount}, 32'd1);
        tick();
        chk("t1_idle",  {30'd0, busy, done}, 32'd0);

        // Burst of four, J marked last
        startSession();
        apply(3'd2, 5'd8, 5'd9, 5'd0, 6'd0, 16'h00FF, 26'd0, 1'b0);
        chk("b0_we",   {31'd0, imemWe},   32'd1);
        chk("b0_addr", {24'd0, imemAddr}, 32'd0);
        chk("b0_data", imemWdata,         32'h3509_00FF);
        tick();
        chk("b0_gap",  {30'd0, imemWe, reqReady}, 32'd1);
        apply(3'd3, 5'd9, 5'd10, 5'd0, 6'd0, 16'h0F0F, 26'd0, 1'b0);
        chk("b1_addr", {24'd0, imemAddr}, 32'd1);
        chk("b1_data", imemWdata,         32'h312A_0F0F);
        tick();
        chk("b1_gap",  {31'd0, imemWe},   32'd0);
        apply(3'd0, 5'd8, 5'd9, 5'd10, 6'h20, 16'd0, 26'd0, 1'b0);
        chk("b2_addr", {24'd0, imemAddr}, 32'd2);
        chk("b2_data", imemWdata,         32'h0109_5020);
        tick();
        apply(3'd4, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h010_0000, 1'b1);
        chk("b3_we",   {31'd0, imemWe},   32'd1);
        chk("b3_addr", {24'd0, imemAddr}, 32'd3);
        chk("b3_data", imemWdata,         32'h0810_0000);
        tick();
        chk("b_done",  {31'd0, done},     32'd1);
        chk("b_count", {23'd0, wordCount}, 32'd4);
        tick();

        // Full without last: four ANDI writes, then a fifth request is refused
        startSession();
        for (int k = 0; k < 4; k++) begin
            apply(3'd3, 5'd1, 5'd2, 5'd0, 6'd0, 16'(k), 26'd0, 1'b0);
            chk("f_addr", {24'd0, imemAddr}, 32'(k));
            chk("f_data", imemWdata, 32'h3022_0000 + 32'(k));
            tick();
        end
        chk("f_done",  {30'd0, done, reqReady}, 32'd2);
        chk("f_count", {23'd0, wordCount}, 32'd4);
        reqValid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("f_refuse", {29'd0, reqReady, imemWe, busy}, 32'd0);
        end
        reqValid = 1'b0;
        chk("f_count_hold", {23'd0, wordCount}, 32'd4);

        // Illegal op_sel mid-session
        startSession();
        apply(3'd2, 5'd8, 5'd9, 5'd0, 6'd0, 16'h00FF, 26'd0, 1'b0);
        tick();
        apply(3'd6, 5'd3, 5'd4, 5'd5, 6'h3F, 16'hFFFF, 26'h3FF_FFFF, 1'b0);
`ifdef ENCODER_CHECK_EN
        chk("ill_err",   {31'd0, err},       32'd1);
        chk("ill_nowe",  {31'd0, imemWe},    32'd0);
        chk("ill_count", {23'd0, wordCount}, 32'd1);
        apply(3'd1, 5'd0, 5'd8, 5'd0, 6'd0, 16'd5, 26'd0, 1'b1);
        chk("ill_next_addr", {24'd0, imemAddr}, 32'd1);
        chk("ill_next_data", imemWdata,         32'h2008_0005);
        tick();
        chk("ill_final_count", {23'd0, wordCount}, 32'd2);
`else
        chk("ill_err",   {31'd0, err},      32'd0);
        chk("ill_we",    {31'd0, imemWe},   32'd1);
        chk("ill_addr",  {24'd0, imemAddr}, 32'd1);
        chk("ill_data",  imemWdata,         32'h0000_0000);
        tick();
        chk("ill_count", {23'd0, wordCount}, 32'd2);
        apply(3'd1, 5'd0, 5'd8, 5'd0, 6'd0, 16'd5, 26'd0, 1'b1);
        chk("ill_next_addr", {24'd0, imemAddr}, 32'd2);
        chk("ill_next_data", imemWdata,         32'h2008_0005);
        tick();
        chk("ill_final_count", {23'd0, wordCount}, 32'd3);
`endif
        chk("ill_done", {31'd0, done}, 32'd1);
        tick();

        // Reset asserted during the second WRITE
        startSession();
        apply(3'd2, 5'd1, 5'd1, 5'd0, 6'd0, 16'h1234, 26'd0, 1'b0);
        tick();
        apply(3'd2, 5'd1, 5'd1, 5'd0, 6'd0, 16'h5678, 26'd0, 1'b0);
        chk("r_we_pre", {31'd0, imemWe}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("r_we",    {31'd0, imemWe},     32'd0);
        chk("r_busy",  {31'd0, busy},       32'd0);
        chk("r_count", {23'd0, wordCount},  32'd0);
        chk("r_addr",  {24'd0, imemAddr},   32'd0);
        chk("r_wdata", imemWdata,           32'd0);
        reset = 1'b1;
        reqValid = 1'b1;
        tick(); tick();
        chk("r_need_start", {30'd0, busy, reqReady}, 32'd0);
        reqValid = 1'b0;
        startSession();
        apply(3'd1, 5'd0, 5'd8, 5'd0, 6'd0, 16'd5, 26'd0, 1'b1);
        chk("r_restart_addr", {24'd0, imemAddr}, 32'd0);
        chk("r_restart_data", imemWdata,         32'h2008_0005);
        tick(); tick();

        // req_valid in IDLE ignored; start in ACCEPT ignored
        opSel = 3'd1; reqValid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("idle_valid", {29'd0, busy, reqReady, imemWe}, 32'd0);
        end
        reqValid = 1'b0;
        chk("idle_count", {23'd0, wordCount}, 32'd1);
        startSession();
        apply(3'd2, 5'd2, 5'd3, 5'd0, 6'd0, 16'h00AA, 26'd0, 1'b0);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("acc_start", {29'd0, busy, reqReady, imemWe}, 32'd6);
        chk("acc_count", {23'd0, wordCount}, 32'd1);
        apply(3'd1, 5'd0, 5'd8, 5'd0, 6'd0, 16'd5, 26'd0, 1'b1);
        chk("acc_addr", {24'd0, imemAddr}, 32'd1);
        tick();
        chk("acc_done", {31'd0, done}, 32'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
